// File: rtl/if_mem_pkg.sv
// Shared definitions for the IF-stage instruction memory and its byte-stream loader:
// FSM encodings, the fetch NOP value and the default halt-word fill.
package if_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // The default halt word is this bit replicated across the instruction width.
  localparam logic DEFAULT_HALT_BIT = 1'b1;

endpackage

// File: rtl/if_instruction_memory_loader_if.sv
// Loader byte stream and PC-stage fetch port of the IF instruction memory.
interface if_instruction_memory_loader_if #(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32
);

  // Loader handshake: a byte moves on a rising edge where i_byte_valid && o_byte_ready.
  // i_byte is held stable while i_byte_valid waits for o_byte_ready; o_byte_ready
  // does not depend combinationally on i_byte_valid.
  logic               i_load_start;
  logic               i_byte_valid;
  logic [7:0]         i_byte;
  logic               o_byte_ready;

  // Fetch port: i_pc sampled when i_fetch_en=1, result valid one edge later.
  logic [NB_ADDR-1:0] i_pc;
  logic               i_fetch_en;
  logic [NB_INST-1:0] o_instruction;
  logic               o_inst_valid;

  modport master (
    output i_load_start, i_byte_valid, i_byte, i_pc, i_fetch_en,
    input  o_byte_ready, o_instruction, o_inst_valid
  );

  modport slave (
    input  i_load_start, i_byte_valid, i_byte, i_pc, i_fetch_en,
    output o_byte_ready, o_instruction, o_inst_valid
  );

endinterface

// File: rtl/if_imem_ram.sv
// Instruction storage: one write port, one registered read port.
// No reset on the array so loaded programs survive a reset.
module if_imem_ram #(
  parameter int NB_INST     = 32,
  parameter int NB_ROM_SIZE = 10
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [NB_ROM_SIZE-1:0] i_waddr,
  input  logic [NB_INST-1:0]     i_wdata,
  input  logic                   i_re,
  input  logic [NB_ROM_SIZE-1:0] i_raddr,
  output logic [NB_INST-1:0]     o_rdata
);

  logic [NB_INST-1:0] mem [2**NB_ROM_SIZE];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/if_instruction_memory_loader.sv
// IF-stage instruction memory with an integrated byte-stream program loader.
// Bytes are packed into words, written at an auto-incrementing pointer, then served as fetches.
module if_instruction_memory_loader
  import if_mem_pkg::*;
#(
  parameter int                 NB_ADDR     = 32,
  parameter int                 NB_INST     = 32,
  parameter int                 NB_ROM_SIZE = 10,
  parameter int                 TAM         = 2**NB_ROM_SIZE,
  parameter bit                 BIG_ENDIAN  = 1'b1,
  parameter logic [NB_INST-1:0] HALT_WORD   = {NB_INST{DEFAULT_HALT_BIT}}
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  if_instruction_memory_loader_if.slave bus,
  output logic                          o_loaded,
  output logic [NB_ROM_SIZE:0]          o_word_count,
  output logic                          o_overflow,
  output state_t                        o_state
);

  localparam int BYTES   = NB_INST / 8;
  localparam int NB_BCNT = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [NB_INST-1:0] NOP = NB_INST'(NOP_WORD);

  state_t               state_q, state_d;
  logic [NB_ROM_SIZE:0] ptr_q;
  logic [NB_BCNT-1:0]   bcnt_q;
  logic [NB_INST-9:0]   partial_q, partial_d;
  logic [NB_INST-1:0]   word_nxt;
  logic                 xfer, last_byte, word_done, do_write, do_ovf, is_halt;
  logic                 in_ready, fetch, pc_bad;
  logic                 valid_q, nop_q;
  logic [NB_INST-1:0]   ram_rdata;

  // A start pulse wins over a coincident byte, which is dropped.
  assign xfer      = (state_q == ST_LOAD) && bus.i_byte_valid && !bus.i_load_start;
  assign last_byte = (bcnt_q == NB_BCNT'(BYTES - 1));
  assign word_done = xfer && last_byte;
  assign do_write  = word_done && !ptr_q[NB_ROM_SIZE];
  assign do_ovf    = word_done && ptr_q[NB_ROM_SIZE];
  assign is_halt   = do_write && (word_nxt == HALT_WORD);

  // partial_q holds the bytes received so far; the final byte completes the word.
  generate
    if (BIG_ENDIAN) begin : g_be
      assign word_nxt  = {partial_q, bus.i_byte};
      assign partial_d = word_nxt[NB_INST-9:0];
    end else begin : g_le
      assign word_nxt  = {bus.i_byte, partial_q};
      assign partial_d = word_nxt[NB_INST-1:8];
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.i_load_start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD:  if (is_halt || do_ovf) state_d = ST_READY;
        ST_READY: state_d = ST_READY;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.o_byte_ready = (state_q == ST_LOAD);
    o_loaded         = (state_q == ST_READY);
    o_state          = state_q;
  end

  // Loader datapath: write pointer doubles as the word count of the current load.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ptr_q      <= '0;
      bcnt_q     <= '0;
      partial_q  <= '0;
      o_overflow <= 1'b0;
    end else if (bus.i_load_start) begin
      ptr_q      <= '0;
      bcnt_q     <= '0;
      partial_q  <= '0;
      o_overflow <= 1'b0;
    end else if (xfer) begin
      partial_q <= partial_d;
      bcnt_q    <= last_byte ? '0 : bcnt_q + 1'b1;
      if (do_write) ptr_q <= ptr_q + 1'b1;
      if (do_ovf)   o_overflow <= 1'b1;
    end
  end

  assign o_word_count = ptr_q;

  // Misaligned or beyond-depth addresses return NOP rather than aliasing into the array.
  assign in_ready = (state_q == ST_READY) && !bus.i_load_start;
  assign fetch    = in_ready && bus.i_fetch_en;
  assign pc_bad   = (bus.i_pc[1:0] != 2'b00) ||
                    ((bus.i_pc >> (NB_ROM_SIZE + 2)) != '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q <= 1'b0;
      nop_q   <= 1'b0;
    end else if (!in_ready) begin
      valid_q <= 1'b0;
      nop_q   <= 1'b0;
    end else if (bus.i_fetch_en) begin
      valid_q <= 1'b1;
      nop_q   <= pc_bad;
    end
  end

  assign bus.o_inst_valid  = valid_q;
  assign bus.o_instruction = (valid_q && !nop_q) ? ram_rdata : NOP;

  if_imem_ram #(
    .NB_INST     (NB_INST),
    .NB_ROM_SIZE (NB_ROM_SIZE)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (do_write),
    .i_waddr (ptr_q[NB_ROM_SIZE-1:0]),
    .i_wdata (word_nxt),
    .i_re    (fetch),
    .i_raddr (bus.i_pc[NB_ROM_SIZE+1:2]),
    .o_rdata (ram_rdata)
  );

endmodule

// File: tb/tb_if_instruction_memory_loader.sv
// Directed bench: big-endian 1K-word instance (a) and little-endian 4-word instance (b).
module tb_if_instruction_memory_loader;
  import if_mem_pkg::*;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic   i_clk = 1'b0;
  logic   i_reset = 1'b0;
  logic   loaded_a, overflow_a, loaded_b, overflow_b;
  logic [10:0] wc_a;
  logic [2:0]  wc_b;
  state_t st_a, st_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] w0, w1;

  if_instruction_memory_loader_if #(.NB_ADDR(32), .NB_INST(32)) bus_a ();
  if_instruction_memory_loader_if #(.NB_ADDR(32), .NB_INST(32)) bus_b ();

  if_instruction_memory_loader #(.NB_ROM_SIZE(10), .BIG_ENDIAN(1'b1)) dut_a (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus_a.slave),
    .o_loaded(loaded_a), .o_word_count(wc_a), .o_overflow(overflow_a), .o_state(st_a)
  );

  if_instruction_memory_loader #(.NB_ROM_SIZE(2), .BIG_ENDIAN(1'b0)) dut_b (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus_b.slave),
    .o_loaded(loaded_b), .o_word_count(wc_b), .o_overflow(overflow_b), .o_state(st_b)
  );

  // Clock and watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic start_load(input bit sel);
    @(negedge i_clk);
    if (!sel) bus_a.i_load_start = 1'b1; else bus_b.i_load_start = 1'b1;
    @(posedge i_clk);
    #1;
    bus_a.i_load_start = 1'b0;
    bus_b.i_load_start = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    @(negedge i_clk);
    if (!sel) begin
      bus_a.i_byte_valid = 1'b1; bus_a.i_byte = b;
    end else begin
      bus_b.i_byte_valid = 1'b1; bus_b.i_byte = b;
    end
    @(posedge i_clk);
    #1;
    bus_a.i_byte_valid = 1'b0;
    bus_b.i_byte_valid = 1'b0;
  endtask

  // Instance a is big-endian (MSB first), instance b little-endian (LSB first).
  task automatic send_word(input bit sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      if (!sel) send_byte(sel, w[31-8*i -: 8]);
      else      send_byte(sel, w[8*i +: 8]);
    end
  endtask

  // Scoreboard: expectation pushed at drive time, popped when the result appears.
  task automatic fetch(input bit sel, input logic [31:0] pc, input logic [31:0] exp,
                       input string tag);
    logic [31:0] e;
    @(negedge i_clk);
    if (!sel) begin
      bus_a.i_pc = pc; bus_a.i_fetch_en = 1'b1;
    end else begin
      bus_b.i_pc = pc; bus_b.i_fetch_en = 1'b1;
    end
    exp_q.push_back(exp);
    @(posedge i_clk);
    #1;
    bus_a.i_fetch_en = 1'b0;
    bus_b.i_fetch_en = 1'b0;
    e = exp_q.pop_front();
    if (!sel) begin
      check({tag, "_valid"}, {31'b0, bus_a.o_inst_valid}, 32'd1);
      check(tag, bus_a.o_instruction, e);
    end else begin
      check({tag, "_valid"}, {31'b0, bus_b.o_inst_valid}, 32'd1);
      check(tag, bus_b.o_instruction, e);
    end
  endtask

  initial begin
    bus_a.i_load_start = 1'b0; bus_a.i_byte_valid = 1'b0; bus_a.i_byte = '0;
    bus_a.i_pc = '0; bus_a.i_fetch_en = 1'b0;
    bus_b.i_load_start = 1'b0; bus_b.i_byte_valid = 1'b0; bus_b.i_byte = '0;
    bus_b.i_pc = '0; bus_b.i_fetch_en = 1'b0;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_instr", bus_a.o_instruction, 32'h0);
    check("rst_valid", {31'b0, bus_a.o_inst_valid}, 32'd0);
    check("rst_loaded", {31'b0, loaded_a}, 32'd0);
    check("rst_wcount", {21'b0, wc_a}, 32'd0);
    check("rst_ovf", {31'b0, overflow_a}, 32'd0);
    check("rst_ready", {31'b0, bus_a.o_byte_ready}, 32'd0);
    check("rst_state", {30'b0, st_a}, {30'b0, ST_IDLE});
    i_reset = 1'b1;

    // Fetch in IDLE is ignored
    @(negedge i_clk);
    bus_a.i_pc = 32'd0; bus_a.i_fetch_en = 1'b1;
    @(posedge i_clk); #1;
    bus_a.i_fetch_en = 1'b0;
    check("idle_fetch_valid", {31'b0, bus_a.o_inst_valid}, 32'd0);
    check("idle_fetch_instr", bus_a.o_instruction, 32'h0);

    // Big-endian load of three words ending in the halt word
    start_load(1'b0);
    check("load_ready", {31'b0, bus_a.o_byte_ready}, 32'd1);
    check("load_state", {30'b0, st_a}, {30'b0, ST_LOAD});
    send_word(1'b0, 32'h0043_0821);
    send_word(1'b0, 32'h0800_000B);
    check("mid_wcount", {21'b0, wc_a}, 32'd2);
    check("mid_loaded", {31'b0, loaded_a}, 32'd0);
    send_word(1'b0, HALT);
    check("halt_wcount", {21'b0, wc_a}, 32'd3);
    check("halt_loaded", {31'b0, loaded_a}, 32'd1);
    check("halt_ready", {31'b0, bus_a.o_byte_ready}, 32'd0);
    check("halt_ovf", {31'b0, overflow_a}, 32'd0);
    check("halt_state", {30'b0, st_a}, {30'b0, ST_READY});
    fetch(1'b0, 32'd0, 32'h0043_0821, "fetch_pc0");
    fetch(1'b0, 32'd4, 32'h0800_000B, "fetch_pc4");
    fetch(1'b0, 32'd8, HALT, "fetch_pc8");

    // NOP on misaligned and out-of-range addresses, then a stall
    fetch(1'b0, 32'd6, 32'h0, "fetch_misaligned");
    fetch(1'b0, 32'd4096, 32'h0, "fetch_out_of_range");
    fetch(1'b0, 32'd4, 32'h0800_000B, "fetch_pre_stall");
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      bus_a.i_pc = 32'd0;
      check("stall_instr", bus_a.o_instruction, 32'h0800_000B);
      check("stall_valid", {31'b0, bus_a.o_inst_valid}, 32'd1);
    end

    // Reload with random non-halt words
    w0 = $urandom_range(0, 32'h7FFF_FFFF);
    w1 = $urandom_range(0, 32'h7FFF_FFFF);
    start_load(1'b0);
    send_word(1'b0, w0);
    send_word(1'b0, w1);
    send_word(1'b0, HALT);
    check("rand_wcount", {21'b0, wc_a}, 32'd3);
    fetch(1'b0, 32'd0, w0, "rand_pc0");
    fetch(1'b0, 32'd4, w1, "rand_pc4");

    // Reset after two bytes of a load, then a fresh load from word 0
    start_load(1'b0);
    send_byte(1'b0, 8'hCA);
    send_byte(1'b0, 8'hFE);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    check("mrst_instr", bus_a.o_instruction, 32'h0);
    check("mrst_valid", {31'b0, bus_a.o_inst_valid}, 32'd0);
    check("mrst_loaded", {31'b0, loaded_a}, 32'd0);
    check("mrst_wcount", {21'b0, wc_a}, 32'd0);
    check("mrst_ready", {31'b0, bus_a.o_byte_ready}, 32'd0);
    check("mrst_state", {30'b0, st_a}, {30'b0, ST_IDLE});
    @(negedge i_clk);
    i_reset = 1'b1;
    start_load(1'b0);
    send_word(1'b0, 32'hCAFE_0001);
    send_word(1'b0, HALT);
    check("after_rst_wcount", {21'b0, wc_a}, 32'd2);
    fetch(1'b0, 32'd0, 32'hCAFE_0001, "after_rst_pc0");
    fetch(1'b0, 32'd4, HALT, "after_rst_pc4");

    // Start coinciding with a byte in READY: start wins, byte dropped
    @(negedge i_clk);
    bus_a.i_load_start = 1'b1; bus_a.i_byte_valid = 1'b1; bus_a.i_byte = 8'h12;
    @(posedge i_clk); #1;
    bus_a.i_load_start = 1'b0; bus_a.i_byte_valid = 1'b0;
    check("coll_loaded", {31'b0, loaded_a}, 32'd0);
    check("coll_wcount", {21'b0, wc_a}, 32'd0);
    check("coll_ready", {31'b0, bus_a.o_byte_ready}, 32'd1);
    check("coll_valid", {31'b0, bus_a.o_inst_valid}, 32'd0);
    check("coll_instr", bus_a.o_instruction, 32'h0);
    send_word(1'b0, 32'h1122_3344);
    send_word(1'b0, HALT);
    check("coll_wcount2", {21'b0, wc_a}, 32'd2);
    fetch(1'b0, 32'd0, 32'h1122_3344, "coll_pc0");

    // Little-endian, 4-word instance: overflow on the fifth word
    start_load(1'b1);
    send_byte(1'b1, 8'h21);
    send_byte(1'b1, 8'h08);
    send_byte(1'b1, 8'h43);
    send_byte(1'b1, 8'h00);
    send_word(1'b1, 32'h0800_000B);
    send_word(1'b1, 32'h1234_5678);
    send_word(1'b1, 32'h0BAD_F00D);
    check("b_full_wcount", {29'b0, wc_b}, 32'd4);
    check("b_full_loaded", {31'b0, loaded_b}, 32'd0);
    check("b_full_ovf", {31'b0, overflow_b}, 32'd0);
    send_word(1'b1, 32'h0000_0001);
    check("b_ovf", {31'b0, overflow_b}, 32'd1);
    check("b_ovf_wcount", {29'b0, wc_b}, 32'd4);
    check("b_ovf_loaded", {31'b0, loaded_b}, 32'd1);
    check("b_ovf_ready", {31'b0, bus_b.o_byte_ready}, 32'd0);
    fetch(1'b1, 32'd0, 32'h0043_0821, "b_pc0");
    fetch(1'b1, 32'd4, 32'h0800_000B, "b_pc4");
    fetch(1'b1, 32'd8, 32'h1234_5678, "b_pc8");
    fetch(1'b1, 32'd12, 32'h0BAD_F00D, "b_pc12");
    fetch(1'b1, 32'd16, 32'h0, "b_out_of_range");
    start_load(1'b1);
    check("b_restart_ovf", {31'b0, overflow_b}, 32'd0);
    check("b_restart_wcount", {29'b0, wc_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
